// File: rtl/shift_pkg.sv
// Shared types for the shift arbiter slice: ShiftFn codes,
// arbiter FSM states, default datapath width, one-hot helper.
package shift_pkg;

    localparam int SHIFT_WIDTH = 32;

    typedef enum logic [1:0] {
        SHIFT_SLL  = 2'b00,
        SHIFT_SRL  = 2'b01,
        SHIFT_SRA  = 2'b10,
        SHIFT_PASS = 2'b11
    } shift_fn_e;

    typedef enum logic [1:0] {
        ARB_IDLE = 2'b00,
        ARB_EXEC = 2'b01,
        ARB_RESP = 2'b10
    } arb_state_e;

    function automatic logic [1:0] onehot2(input logic idx);
        return idx ? 2'b10 : 2'b01;
    endfunction

endpackage

// File: rtl/shift_arbiter_if.sv
// Request/response bundle between two requesters and the shift arbiter.
// master: requester side (drives req_*, rsp_ready); slave: arbiter side.
interface shift_arbiter_if #(
    parameter int WIDTH = shift_pkg::SHIFT_WIDTH
);
    logic [1:0]       req_valid;
    logic [1:0]       req_ready;
    logic [1:0]       req_fn0;
    logic [1:0]       req_fn1;
    logic             req_cv0;
    logic             req_cv1;
    logic [WIDTH-1:0] req_x0;
    logic [WIDTH-1:0] req_x1;
    logic [WIDTH-1:0] req_y0;
    logic [WIDTH-1:0] req_y1;
    logic [1:0]       rsp_valid;
    logic [1:0]       rsp_ready;
    logic [WIDTH-1:0] rsp_data;

    modport master (
        output req_valid, req_fn0, req_fn1, req_cv0, req_cv1,
        output req_x0, req_x1, req_y0, req_y1, rsp_ready,
        input  req_ready, rsp_valid, rsp_data
    );

    modport slave (
        input  req_valid, req_fn0, req_fn1, req_cv0, req_cv1,
        input  req_x0, req_x1, req_y0, req_y1, rsp_ready,
        output req_ready, rsp_valid, rsp_data
    );

endinterface

// File: rtl/rr_arb2.sv
// Combinational 2-way round-robin grant.
// in: req_valid[1:0], prio; out: gnt (one-hot or 0), gnt_idx.
module rr_arb2
    import shift_pkg::*;
(
    input  logic [1:0] req_valid,
    input  logic       prio,
    output logic [1:0] gnt,
    output logic       gnt_idx
);

    always_comb begin
        gnt     = 2'b00;
        gnt_idx = 1'b0;
        unique case (req_valid)
            2'b01: begin
                gnt     = 2'b01;
                gnt_idx = 1'b0;
            end
            2'b10: begin
                gnt     = 2'b10;
                gnt_idx = 1'b1;
            end
            2'b11: begin
                gnt     = onehot2(prio);
                gnt_idx = prio;
            end
            default: begin
                gnt     = 2'b00;
                gnt_idx = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/shift_unit.sv
// Combinational shifter: SHL, SRL, SRA or pass-through of x.
// in: fn, cv (amount = y[0] only), x, y; out: res.
module shift_unit
    import shift_pkg::*;
#(
    parameter int WIDTH = SHIFT_WIDTH
) (
    input  logic [1:0]       fn,
    input  logic             cv,
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    output logic [WIDTH-1:0] res
);

    localparam int SB = $clog2(WIDTH);

    shift_fn_e        fn_e;
    logic [WIDTH-1:0] amt;
    logic [SB-1:0]    sh;
    logic             ovf;

    assign fn_e = shift_fn_e'(fn);
    assign amt  = cv ? {{(WIDTH-1){1'b0}}, y[0]} : y;
    assign sh   = amt[SB-1:0];
    // Any bit above the in-range shift field means amount >= WIDTH.
    assign ovf  = |amt[WIDTH-1:SB];

    always_comb begin
        res = x;
        unique case (fn_e)
            SHIFT_SLL:  res = ovf ? '0 : (x << sh);
            SHIFT_SRL:  res = ovf ? '0 : (x >> sh);
            SHIFT_SRA:  res = ovf ? {WIDTH{x[WIDTH-1]}}
                                  : $unsigned($signed(x) >>> sh);
            SHIFT_PASS: res = x;
            default:    res = x;
        endcase
    end

endmodule

// File: rtl/shift_arbiter.sv
// Shares one shift_unit between two requesters, one op in flight.
// Ports: clk, rst (async high), bus (slave modport), busy.
module shift_arbiter
    import shift_pkg::*;
#(
    parameter int WIDTH = SHIFT_WIDTH
) (
    input  logic           clk,
    input  logic           rst,
    shift_arbiter_if.slave bus,
    output logic           busy
);

    arb_state_e       state_q;
    arb_state_e       state_d;
    logic             prio_q;
    logic             owner_q;
    logic [1:0]       fn_q;
    logic             cv_q;
    logic [WIDTH-1:0] x_q;
    logic [WIDTH-1:0] y_q;
    logic [WIDTH-1:0] res;
    logic [WIDTH-1:0] rsp_data_q;
    logic [1:0]       rsp_valid_q;
    logic [1:0]       gnt;
    logic             gnt_idx;
    logic             idle;
    logic             accept;
    logic             rsp_take;

    rr_arb2 u_arb (
        .req_valid (bus.req_valid),
        .prio      (prio_q),
        .gnt       (gnt),
        .gnt_idx   (gnt_idx)
    );

    shift_unit #(
        .WIDTH (WIDTH)
    ) u_shift (
        .fn  (fn_q),
        .cv  (cv_q),
        .x   (x_q),
        .y   (y_q),
        .res (res)
    );

    // rst gates the grant so req_ready reads 0 while reset is held.
    assign idle     = (state_q == ARB_IDLE) && !rst;
    assign accept   = idle && (gnt != 2'b00);
    assign rsp_take = (state_q == ARB_RESP)
                   && bus.rsp_ready[owner_q];

    assign bus.req_ready = idle ? gnt : 2'b00;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_data  = rsp_data_q;
    assign busy          = (state_q != ARB_IDLE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ARB_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ARB_IDLE: if (accept)   state_d = ARB_EXEC;
            ARB_EXEC:               state_d = ARB_RESP;
            ARB_RESP: if (rsp_take) state_d = ARB_IDLE;
            default:                state_d = ARB_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prio_q  <= 1'b0;
            owner_q <= 1'b0;
            fn_q    <= 2'b00;
            cv_q    <= 1'b0;
            x_q     <= '0;
            y_q     <= '0;
        end else if (accept) begin
            owner_q <= gnt_idx;
            prio_q  <= ~gnt_idx;
            fn_q    <= gnt_idx ? bus.req_fn1 : bus.req_fn0;
            cv_q    <= gnt_idx ? bus.req_cv1 : bus.req_cv0;
            x_q     <= gnt_idx ? bus.req_x1  : bus.req_x0;
            y_q     <= gnt_idx ? bus.req_y1  : bus.req_y0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rsp_valid_q <= 2'b00;
            rsp_data_q  <= '0;
        end else if (state_q == ARB_EXEC) begin
            rsp_valid_q <= onehot2(owner_q);
            rsp_data_q  <= res;
        end else if (rsp_take) begin
            rsp_valid_q <= 2'b00;
        end
    end

endmodule

// File: tb/tb_shift_arbiter.sv
// Bench for shift_arbiter: directed cases plus random traffic
// checked cycle by cycle against a transaction-level model.
module tb_shift_arbiter;
    import shift_pkg::*;

    logic clk = 1'b0;
    logic rst;
    logic busy;

    always #5 clk = ~clk;

    shift_arbiter_if #(.WIDTH(32)) bus ();

    shift_arbiter #(.WIDTH(32)) dut (
        .clk  (clk),
        .rst  (rst),
        .bus  (bus),
        .busy (busy)
    );

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Operands presented by each requester.
    logic [1:0]  op_fn [2];
    logic        op_cv [2];
    logic [31:0] op_x  [2];
    logic [31:0] op_y  [2];

    // Model: at most one op outstanding, age = edges since accept.
    bit          m_has;
    bit          m_prio;
    int          m_owner;
    int          m_age;
    logic [31:0] m_res;
    int          cyc_n;
    int          obs_own [$];
    int          obs_cyc [$];

    function automatic logic [31:0] ref_shift(input logic [1:0] fn,
            input logic cv, input logic [31:0] x, input logic [31:0] y);
        int unsigned amt;
        int          n;
        logic [31:0] r;
        amt = cv ? {31'b0, y[0]} : y;
        n   = (amt > 32) ? 32 : int'(amt);
        r   = x;
        for (int i = 0; i < n; i++) begin
            case (fn)
                2'b00:   r = {r[30:0], 1'b0};
                2'b01:   r = {1'b0, r[31:1]};
                2'b10:   r = {r[31], r[31:1]};
                default: r = x;
            endcase
        end
        return r;
    endfunction

    function automatic logic [1:0] exp_grant(input logic [1:0] v,
                                             input bit p);
        if (v == 2'b11) return p ? 2'b10 : 2'b01;
        return v;
    endfunction

    task automatic drive_ops();
        bus.req_fn0 = op_fn[0];
        bus.req_fn1 = op_fn[1];
        bus.req_cv0 = op_cv[0];
        bus.req_cv1 = op_cv[1];
        bus.req_x0  = op_x[0];
        bus.req_x1  = op_x[1];
        bus.req_y0  = op_y[0];
        bus.req_y1  = op_y[1];
    endtask

    // One clock cycle, entered and left at a negedge.
    task automatic cyc(input logic [1:0] v, input logic [1:0] rr);
        logic [1:0] er;
        bit         done;
        bit         vld;
        vld = m_has && (m_age >= 1);
        chk("busy", busy, m_has);
        chk("rsp_valid", bus.rsp_valid,
            vld ? (32'd1 << m_owner) : 32'd0);
        if (vld) chk("rsp_data", bus.rsp_data, m_res);
        drive_ops();
        bus.req_valid = v;
        bus.rsp_ready = rr;
        #1;
        er = m_has ? 2'b00 : exp_grant(v, m_prio);
        chk("req_ready", bus.req_ready, er);
        if ((bus.req_ready & v) != 2'b00) begin
            obs_own.push_back(bus.req_ready[1] ? 1 : 0);
            obs_cyc.push_back(cyc_n);
        end
        done = vld && rr[m_owner];
        @(posedge clk);
        cyc_n++;
        if (m_has) m_age++;
        if (done) begin
            m_has = 1'b0;
        end else if (er != 2'b00) begin
            m_has   = 1'b1;
            m_owner = er[1] ? 1 : 0;
            m_age   = 0;
            m_res   = ref_shift(op_fn[m_owner], op_cv[m_owner],
                                op_x[m_owner], op_y[m_owner]);
            m_prio  = (m_owner == 0);
        end
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        #1;
        chk("rst_busy", busy, 0);
        chk("rst_rsp_valid", bus.rsp_valid, 0);
        chk("rst_rsp_data", bus.rsp_data, 0);
        chk("rst_req_ready", bus.req_ready, 0);
        @(negedge clk);
        rst    = 1'b0;
        m_has  = 1'b0;
        m_prio = 1'b0;
    endtask

    task automatic op(input int r, input logic [1:0] fn,
                      input logic cv, input logic [31:0] x,
                      input logic [31:0] y, input logic [31:0] want,
                      input string tag);
        int n0;
        int g;
        n0 = obs_own.size();
        g  = 0;
        op_fn[r] = fn;
        op_cv[r] = cv;
        op_x[r]  = x;
        op_y[r]  = y;
        while (!m_has && g < 8) begin
            cyc((r == 0) ? 2'b01 : 2'b10, 2'b00);
            g++;
        end
        chk({tag, "_acc"}, obs_own.size() - n0, 1);
        cyc(2'b00, 2'b00);
        chk({tag, "_vld"}, bus.rsp_valid, (r == 0) ? 1 : 2);
        chk(tag, bus.rsp_data, want);
        cyc(2'b00, 2'b11);
    endtask

    task automatic rand_ops();
        for (int i = 0; i < 2; i++) begin
            op_fn[i] = 2'($urandom_range(0, 3));
            op_cv[i] = 1'($urandom_range(0, 1));
            op_x[i]  = $urandom;
            op_y[i]  = ($urandom_range(0, 1) != 0)
                     ? 32'($urandom_range(0, 40)) : $urandom;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    initial begin
        int          n0;
        logic [31:0] held;
        cyc_n = 0;
        for (int i = 0; i < 2; i++) begin
            op_fn[i] = 2'b00;
            op_cv[i] = 1'b0;
            op_x[i]  = '0;
            op_y[i]  = '0;
        end
        drive_ops();
        bus.req_valid = 2'b11;
        bus.rsp_ready = 2'b00;
        do_reset();

        op(0, 2'b00, 1'b0, 32'h1, 32'd4, 32'h10, "shl");
        op(1, 2'b10, 1'b0, 32'h8000_0000, 32'd31,
           32'hFFFF_FFFF, "sra31");
        op(1, 2'b10, 1'b0, 32'h8000_0000, 32'd40,
           32'hFFFF_FFFF, "sra40");
        op(1, 2'b01, 1'b0, 32'h8000_0000, 32'd40, 32'h0, "srl40");
        op(0, 2'b00, 1'b1, 32'h3, 32'h7, 32'h6, "cv_y7");
        op(0, 2'b00, 1'b1, 32'h3, 32'h6, 32'h3, "cv_y6");
        op(0, 2'b11, 1'b0, 32'hDEAD_BEEF, 32'd5,
           32'hDEAD_BEEF, "pass");

        // Contention from reset.
        do_reset();
        rand_ops();
        n0 = obs_own.size();
        repeat (12) cyc(2'b11, 2'b11);
        chk("cont_count", obs_own.size() - n0, 4);
        for (int k = 0; k < 4; k++) begin
            if (n0 + k < obs_own.size()) begin
                chk("cont_owner", obs_own[n0 + k], k % 2);
                if (k > 0)
                    chk("cont_gap",
                        obs_cyc[n0 + k] - obs_cyc[n0 + k - 1], 3);
            end
        end
        while (m_has) cyc(2'b00, 2'b11);

        // Backpressure on requester 0 while requester 1 waits.
        op_fn[0] = 2'b01;
        op_cv[0] = 1'b0;
        op_x[0]  = 32'hF000_0000;
        op_y[0]  = 32'd8;
        while (!m_has) cyc(2'b01, 2'b00);
        cyc(2'b10, 2'b10);
        chk("bp_data", bus.rsp_data, 32'h00F0_0000);
        held = bus.rsp_data;
        repeat (5) begin
            cyc(2'b10, 2'b10);
            chk("bp_hold", bus.rsp_data, held);
            chk("bp_stall", bus.req_ready, 0);
        end
        cyc(2'b10, 2'b01);
        n0 = obs_own.size();
        cyc(2'b10, 2'b11);
        chk("bp_next", (obs_own.size() > n0) ? obs_own[n0] : -1, 1);
        while (m_has) cyc(2'b00, 2'b11);

        // Reset in EXEC after a req0 accept left prio pointing at req1.
        op_x[0] = 32'h0000_00FF;
        while (!m_has) cyc(2'b01, 2'b00);
        bus.req_valid = 2'b11;
        #2;
        rst = 1'b1;
        #1;
        chk("mid_busy", busy, 0);
        chk("mid_rsp_valid", bus.rsp_valid, 0);
        chk("mid_rsp_data", bus.rsp_data, 0);
        chk("mid_req_ready", bus.req_ready, 0);
        @(negedge clk);
        rst    = 1'b0;
        m_has  = 1'b0;
        m_prio = 1'b0;
        n0 = obs_own.size();
        cyc(2'b11, 2'b11);
        chk("mid_grant", (obs_own.size() > n0) ? obs_own[n0] : -1, 0);

        // Random traffic.
        repeat (400) begin
            rand_ops();
            cyc(2'($urandom_range(0, 3)),
                {($urandom_range(0, 3) != 0),
                 ($urandom_range(0, 3) != 0)});
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule
